// File: rtl/hilo_md_unit_pkg.sv
// rtl/hilo_md_unit_pkg.sv - shared encodings for the HI/LO multiply/divide unit
//
// Holds the decoder's mulOrdiv encoding and the divider FSM state encoding
// used by hilo_md_unit and its iterative divider.

package hilo_md_unit_pkg;

  // mulOrdiv_i encoding from the main decoder
  localparam logic MUL_OR_DIV_MUL = 1'b1;
  localparam logic MUL_OR_DIV_DIV = 1'b0;

  // Divider sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/hilo_md_unit_div_iter.sv
// rtl/hilo_md_unit_div_iter.sv - restoring shift-subtract divider on unsigned magnitudes
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start_i     : load dividend/divisor magnitudes, clear counter and remainder
//   abort_i     : drop any operation in progress (clears datapath)
//   run_i       : perform one restoring step this cycle
//   dividend_i  : unsigned dividend magnitude
//   divisor_i   : unsigned divisor magnitude (never zero when started)
//   last_o      : the step performed at the coming edge is the final one
//   quot_o      : unsigned quotient (valid once all steps are done)
//   rem_o       : unsigned remainder (valid once all steps are done)

module hilo_md_unit_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             run_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             last_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quo_q;   // dividend shifts out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  // rem_q < divisor always holds, so a clear top bit of diff means the
  // trial remainder was large enough to subtract.
  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]};
    diff  = trial - {1'b0, dvs_q};
  end

  always_ff @(posedge clk) begin
    if (rst || abort_i) begin
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (start_i) begin
      cnt_q <= '0;
      quo_q <= dividend_i;
      rem_q <= '0;
      dvs_q <= divisor_i;
    end else if (run_i) begin
      if (!diff[WIDTH]) begin
        rem_q <= diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= trial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign last_o = (cnt_q == CW'(WIDTH - 1));
  assign quot_o = quo_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/hilo_md_unit.sv
// rtl/hilo_md_unit.sv - execute-stage HI/LO registers with MTHI/MTLO, MULT(U), DIV(U)
//
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   valid_i          : EX holds a live instruction
//   flush_i          : cancel any pending HI/LO effect, return divider to idle
//   hilowrite_i      : decoder says instruction writes HI/LO
//   regToHilo_hi_i   : MTHI
//   regToHilo_lo_i   : MTLO
//   mdToHilo_i       : MULT/MULTU/DIV/DIVU
//   mulOrdiv_i       : 1 = multiply, 0 = divide
//   mdIsSign_i       : signed operation
//   rs_i, rt_i       : operands
//   stall_o          : combinational pipeline hold while a division is pending
//   hi_o, lo_o       : architectural HI/LO
//   busy_o           : divider sequencer not idle

module hilo_md_unit
  import hilo_md_unit_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] HILO_RST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic             flush_i,
  input  logic             hilowrite_i,
  input  logic             regToHilo_hi_i,
  input  logic             regToHilo_lo_i,
  input  logic             mdToHilo_i,
  input  logic             mulOrdiv_i,
  input  logic             mdIsSign_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  output logic             stall_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o
);

  div_state_e state_q, state_d;

  logic             act;
  logic             mul_req;
  logic             div_req;
  logic             rt_zero;
  logic             div_start;
  logic             div_run;
  logic             div_wb;
  logic             div_last;

  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  logic             sign_q_q;
  logic             sign_r_q;
  logic             dz_q;
  logic [WIDTH-1:0] dz_rs_q;

  logic [2*WIDTH-1:0] mul_a;
  logic [2*WIDTH-1:0] mul_b;
  logic [2*WIDTH-1:0] product;

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  assign act     = valid_i & hilowrite_i & ~flush_i;
  assign mul_req = act & mdToHilo_i & (mulOrdiv_i == MUL_OR_DIV_MUL);
  assign div_req = act & mdToHilo_i & (mulOrdiv_i == MUL_OR_DIV_DIV);
  assign rt_zero = (rt_i == '0);

  // Extending both operands to 2*WIDTH and keeping the low half of the
  // product gives the signed or unsigned result from one multiplier.
  always_comb begin
    mul_a   = mdIsSign_i ? {{WIDTH{rs_i[WIDTH-1]}}, rs_i} : {{WIDTH{1'b0}}, rs_i};
    mul_b   = mdIsSign_i ? {{WIDTH{rt_i[WIDTH-1]}}, rt_i} : {{WIDTH{1'b0}}, rt_i};
    product = mul_a * mul_b;
  end

  // The most negative value maps to itself; the unsigned path still
  // treats it as 2^(WIDTH-1), which yields the natural wrap on overflow.
  always_comb begin
    rs_mag = (mdIsSign_i && rs_i[WIDTH-1]) ? (~rs_i + 1'b1) : rs_i;
    rt_mag = (mdIsSign_i && rt_i[WIDTH-1]) ? (~rt_i + 1'b1) : rt_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    stall_o   = 1'b0;
    div_start = 1'b0;
    div_run   = 1'b0;
    div_wb    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (div_req) begin
          stall_o = 1'b1;
          if (rt_zero) begin
            state_d = ST_DONE;
          end else begin
            div_start = 1'b1;
            state_d   = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        stall_o = 1'b1;
        div_run = 1'b1;
        if (div_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        div_wb  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A flush wins over everything the sequencer would otherwise do.
    if (flush_i) begin
      state_d   = ST_IDLE;
      stall_o   = 1'b0;
      div_start = 1'b0;
      div_run   = 1'b0;
      div_wb    = 1'b0;
    end
  end

  hilo_md_unit_div_iter #(
    .WIDTH (WIDTH)
  ) u_div_iter (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .abort_i    (flush_i),
    .run_i      (div_run),
    .dividend_i (rs_mag),
    .divisor_i  (rt_mag),
    .last_o     (div_last),
    .quot_o     (quot),
    .rem_o      (rem)
  );

  // Operand-dependent facts needed at writeback, captured at the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      dz_q     <= 1'b0;
      dz_rs_q  <= '0;
    end else if ((state_q == ST_IDLE) && div_req) begin
      sign_q_q <= mdIsSign_i & (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]);
      sign_r_q <= mdIsSign_i & rs_i[WIDTH-1];
      dz_q     <= rt_zero;
      dz_rs_q  <= rs_i;
    end
  end

  always_comb begin
    quot_fix = sign_q_q ? (~quot + 1'b1) : quot;
    rem_fix  = sign_r_q ? (~rem + 1'b1) : rem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= HILO_RST;
      lo_q <= HILO_RST;
    end else if (div_wb) begin
      if (dz_q) begin
        lo_q <= '1;
        hi_q <= dz_rs_q;
      end else begin
        lo_q <= quot_fix;
        hi_q <= rem_fix;
      end
    end else if (state_q == ST_IDLE) begin
      if (act && regToHilo_hi_i) begin
        hi_q <= rs_i;
      end
      if (act && regToHilo_lo_i) begin
        lo_q <= rs_i;
      end
      if (mul_req) begin
        hi_q <= product[2*WIDTH-1:WIDTH];
        lo_q <= product[WIDTH-1:0];
      end
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hilo_md_unit.sv
// tb/tb_hilo_md_unit.sv - scoreboard bench for hilo_md_unit

module tb_hilo_md_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        flush_i;
  logic        hilowrite_i;
  logic        regToHilo_hi_i;
  logic        regToHilo_lo_i;
  logic        mdToHilo_i;
  logic        mulOrdiv_i;
  logic        mdIsSign_i;
  logic [31:0] rs_i;
  logic [31:0] rt_i;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;

  always #5 clk = ~clk;

  hilo_md_unit #(
    .WIDTH    (32),
    .HILO_RST (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_i        (valid_i),
    .flush_i        (flush_i),
    .hilowrite_i    (hilowrite_i),
    .regToHilo_hi_i (regToHilo_hi_i),
    .regToHilo_lo_i (regToHilo_lo_i),
    .mdToHilo_i     (mdToHilo_i),
    .mulOrdiv_i     (mulOrdiv_i),
    .mdIsSign_i     (mdIsSign_i),
    .rs_i           (rs_i),
    .rt_i           (rt_i),
    .stall_o        (stall_o),
    .hi_o           (hi_o),
    .lo_o           (lo_o),
    .busy_o         (busy_o)
  );

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stall;   // -1: not checked
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   stall_acc = 0;
  logic chk = 1'b0;

  task automatic cmp32(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, got, want);
    end
  endtask

  // Monitor: counts stall cycles and checks the queued expectation when asked.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (stall_o === 1'b1) stall_acc++;
      if (chk) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL scoreboard: check requested with empty queue");
        end else begin
          e = exp_q.pop_front();
          cmp32({e.name, ".hi"}, hi_o, e.hi);
          cmp32({e.name, ".lo"}, lo_o, e.lo);
          n_cmp++;
          if (busy_o !== e.busy) begin
            n_bad++;
            $display("FAIL %s.busy: got %b, expected %b", e.name, busy_o, e.busy);
          end
          if (e.stall >= 0) begin
            n_cmp++;
            if (stall_acc != e.stall) begin
              n_bad++;
              $display("FAIL %s.stall_cycles: got %0d, expected %0d", e.name, stall_acc, e.stall);
            end
          end
        end
        stall_acc = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid_i        = 1'b0;
    hilowrite_i    = 1'b0;
    regToHilo_hi_i = 1'b0;
    regToHilo_lo_i = 1'b0;
    mdToHilo_i     = 1'b0;
    mulOrdiv_i     = 1'b0;
    mdIsSign_i     = 1'b0;
    rs_i           = 32'h0;
    rt_i           = 32'h0;
  endtask

  task automatic expect_now(input string nm, input logic [31:0] h, input logic [31:0] l,
                            input int st, input logic b);
    exp_t e;
    e.name  = nm;
    e.hi    = h;
    e.lo    = l;
    e.stall = st;
    e.busy  = b;
    exp_q.push_back(e);
    chk = 1'b1;
    @(negedge clk);
    #1;
    chk = 1'b0;
  endtask

  // Holds the instruction in EX for one cycle, returns just after the edge that took it.
  task automatic issue(input logic v, input logic rhi, input logic rlo, input logic md,
                       input logic mul, input logic sgn, input logic [31:0] rs,
                       input logic [31:0] rt);
    cyc();
    valid_i        = v;
    hilowrite_i    = 1'b1;
    regToHilo_hi_i = rhi;
    regToHilo_lo_i = rlo;
    mdToHilo_i     = md;
    mulOrdiv_i     = mul;
    mdIsSign_i     = sgn;
    rs_i           = rs;
    rt_i           = rt;
    cyc();
    clear_inputs();
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 100; i++) begin
      if (busy_o === 1'b0) break;
      cyc();
    end
    if (busy_o !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s.timeout: busy_o=%b after 100 cycles, expected 0", nm, busy_o);
    end
  endtask

  task automatic run_div(input string nm, input logic sgn, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] eh, input logic [31:0] el,
                         input int est);
    issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, sgn, rs, rt);
    wait_idle(nm);
    expect_now(nm, eh, el, est, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    flush_i = 1'b0;
    clear_inputs();
    cyc();
    cyc();
    rst = 1'b0;
    expect_now("reset", 32'h0, 32'h0, 0, 1'b0);

    // MTHI / MTLO
    issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678, 32'h0);
    expect_now("mthi", 32'h12345678, 32'h0, 0, 1'b0);
    issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h9ABCDEF0, 32'h0);
    expect_now("mtlo", 32'h12345678, 32'h9ABCDEF0, 0, 1'b0);

    // hilowrite with no select, and a bubble carrying MTHI: neither writes
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h5);
    expect_now("no_select", 32'h12345678, 32'h9ABCDEF0, 0, 1'b0);
    issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0);
    expect_now("bubble_mthi", 32'h12345678, 32'h9ABCDEF0, 0, 1'b0);

    // MULT / MULTU
    issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFE, 32'h3);
    expect_now("mult", 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 1'b0);
    issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFE, 32'h3);
    expect_now("multu", 32'h00000002, 32'hFFFFFFFA, 0, 1'b0);

    // DIV / DIVU
    run_div("div_m7_2",   1'b1, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    run_div("divu_m7_2",  1'b0, 32'hFFFFFFF9, 32'h2,        32'h00000001, 32'h7FFFFFFC, 33);
    run_div("div_7_m2",   1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33);
    run_div("div_ovf",    1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33);
    run_div("divu_1000_7",1'b0, 32'd1000,     32'd7,        32'd6,        32'd142,      33);

    // Divide by zero
    run_div("divu_by0",   1'b0, 32'h00000055, 32'h0,        32'h00000055, 32'hFFFFFFFF, 1);
    run_div("div_by0",    1'b1, 32'hFFFFFFFB, 32'h0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1);

    // Flush during BUSY cycle 10
    issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA, 32'h0);
    expect_now("pre_flush_hi", 32'hA, 32'hFFFFFFFF, 0, 1'b0);
    issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hB, 32'h0);
    expect_now("pre_flush_lo", 32'hA, 32'hB, 0, 1'b0);
    issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd100, 32'd7);
    repeat (9) cyc();
    flush_i = 1'b1;
    expect_now("flush_cycle", 32'hA, 32'hB, 10, 1'b1);
    cyc();
    flush_i = 1'b0;
    expect_now("after_flush", 32'hA, 32'hB, 0, 1'b0);
    repeat (40) cyc();
    expect_now("flush_hold", 32'hA, 32'hB, 0, 1'b0);

    // Reset during BUSY cycle 5, then a multiply
    issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1000, 32'd3);
    repeat (4) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    expect_now("rst_mid_div", 32'h0, 32'h0, -1, 1'b0);
    issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd3, 32'd4);
    expect_now("mult_after_rst", 32'h0, 32'hC, 0, 1'b0);

    repeat (3) cyc();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hilo_md_unit.md
Name: hilo_md_unit

Overview:
- Execute-stage HI/LO block, directly downstream of the main decoder.
- Consumes the decoder's HI/LO control bundle (hilowrite, regToHilo_hi, regToHilo_lo, mdToHilo, mulOrdiv, mdIsSign) after the ID/EX register.
- Performs MTHI/MTLO, single-cycle MULT/MULTU, and iterative 32-step DIV/DIVU.
- Owns the architectural HI/LO registers and raises a pipeline stall while a division runs.

Parameters:
WIDTH, 32, operand width; HI/LO each WIDTH bits; divider runs WIDTH iterations.
HILO_RST, 0, reset value of HI and LO.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
valid_i  in  1  EX holds a live instruction (not a bubble)
flush_i  in  1  exception/ERET flush of EX; cancels any pending HI/LO effect
hilowrite_i  in  1  decoder: instruction writes HI/LO
regToHilo_hi_i  in  1  decoder: MTHI
regToHilo_lo_i  in  1  decoder: MTLO
mdToHilo_i  in  1  decoder: MULT/MULTU/DIV/DIVU
mulOrdiv_i  in  1  1 = multiply, 0 = divide (mulOrdiv_MUL = 1)
mdIsSign_i  in  1  signed operation
rs_i  in  WIDTH  rs operand (dividend/multiplicand, MTHI/MTLO source)
rt_i  in  WIDTH  rt operand (divisor/multiplier)
stall_o  out  1  hold IF/ID/EX; combinational
hi_o  out  WIDTH  current HI register
lo_o  out  WIDTH  current LO register
busy_o  out  1  divider FSM not IDLE (registered)

Behaviour:
- Reset (rst=1 at an edge): HI=LO=HILO_RST, FSM=IDLE, busy_o=0, divider datapath cleared. Reset mid-division aborts with no HI/LO write.
- Accept condition: act = valid_i & hilowrite_i & ~flush_i.
- MTHI: act & regToHilo_hi_i. HI<=rs_i at the edge; LO unchanged; stall_o=0.
- MTLO: act & regToHilo_lo_i. LO<=rs_i; HI unchanged.
- MULT/MULTU: act & mdToHilo_i & mulOrdiv_i. 2*WIDTH product, signed if mdIsSign_i, else zero-extended. {HI,LO}<=product at the same edge. Latency 1, stall_o=0.
- DIV/DIVU: act & mdToHilo_i & ~mulOrdiv_i. FSM states:
  - IDLE: on div request, stall_o=1 combinationally. At the edge, load |rs|, |rt| (magnitudes when signed), record sign_q = rs[msb]^rt[msb] and sign_r = rs[msb], counter=0, go BUSY.
  - BUSY: stall_o=1. One restoring shift-subtract step per cycle; counter++. After WIDTH steps (counter==WIDTH-1 at the edge) go DONE.
  - DONE: stall_o=0. Apply sign fix: quotient negated if sign_q, remainder negated if sign_r. LO<=quotient, HI<=remainder at this edge; go IDLE.
  - Timing: stall_o high for WIDTH+1 cycles (request cycle + WIDTH BUSY cycles); result visible on hi_o/lo_o in the cycle after DONE.
- Divide by zero (rt_i==0): no iteration. IDLE goes straight to DONE (stall 1 cycle). LO<=all-ones, HI<=rs_i.
- flush_i in any state: FSM<=IDLE at the edge; HI/LO untouched; stall_o=0 in the flush cycle.
- While BUSY/DONE, new request inputs are ignored; operands are latched at the request cycle only.
- hilowrite_i with none of the specific selects set: no effect.
- Simultaneous rst and flush_i: rst wins.
- Signed overflow case 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (natural wrap of the magnitude path).

Decomposition:
- control_signal_define.vh: mulOrdiv_MUL/DIV and FSM state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
- One sub-module, div_iter: restoring divider holding magnitudes, counter and partial remainder, with start/abort/done handshake.
- HI/LO registers, multiplier and sign fix-up stay in the top module.

Test Plan:
- MTHI rs=0x12345678, then MTLO rs=0x9ABCDEF0 -> hi_o=0x12345678, lo_o=0x9ABCDEF0 one cycle after each; stall_o never high.
- MULT rs=0xFFFFFFFE, rt=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA next cycle. MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> stall_o high exactly 33 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU same operands -> LO=0x7FFFFFFC, HI=0x00000001.
- DIVU rt=0, rs=0x55 -> stall_o high 1 cycle; LO=0xFFFFFFFF, HI=0x00000055.
- DIV started with HI=0xA, LO=0xB; flush_i at BUSY cycle 10 -> stall_o=0 that cycle; FSM IDLE; HI=0xA, LO=0xB unchanged.
- rst asserted at BUSY cycle 5 -> HI=LO=0, busy_o=0 next cycle. A following MULT 3*4 -> LO=0xC, HI=0.
